// File: rtl/ctrl_decode_pipe_pkg.sv
// Shared encodings for the SNEVA main-control decoder: opcodes, funct fields,
// ALU / immediate / branch / write-back selects and two small decode helpers.
package ctrl_decode_pipe_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_FENCE  = 7'b0001111;
  localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_PASSB, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
    ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_e;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_e;

  typedef enum logic [2:0] {
    BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU, BR_JUMP
  } br_type_e;

  typedef enum logic [1:0] {WB_DMEM, WB_ALU, WB_PC4} wb_sel_e;

  // funct3 -> ALU op for the non-alternate OP / OP-IMM encodings
  function automatic logic [4:0] alu_from_f3(input logic [2:0] f3);
    case (f3)
      3'd0:    return ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // access size (funct3[1:0]) -> LSB-aligned byte lanes
  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode_pipe_comb.sv
// Pure combinational instruction -> control-bundle decode. Illegal encodings
// return an all-zero bundle with illegal=1 so no side effect can leak through.
module ctrl_decode_pipe_comb
  import ctrl_decode_pipe_pkg::*;
#(
  parameter bit EN_M  = 1'b0,
  parameter int ALU_W = 5,
  parameter int BE_W  = 4
) (
  input  logic [31:0]      inst,
  output logic [2:0]       imm_sel,
  output logic             reg_wen,
  output logic             asel,
  output logic             bsel,
  output logic [ALU_W-1:0] alu_sel,
  output logic             dmem_wen,
  output logic             dmem_ren,
  output logic [1:0]       wbsel,
  output logic             usel,
  output logic [BE_W-1:0]  be,
  output logic [2:0]       br_type,
  output logic             illegal
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic [4:0] alu_c;
  logic       legal;
  logic       wen_raw;
  logic       unused_fields;

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  // register/immediate fields are consumed downstream, not by the decoder
  assign unused_fields = ^inst[24:15];

  // decode opcode group, then squash everything if the encoding is illegal
  always_comb begin
    imm_sel  = IMM_I;
    wen_raw  = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    alu_c    = ALU_ADD;
    dmem_wen = 1'b0;
    dmem_ren = 1'b0;
    wbsel    = WB_DMEM;
    usel     = 1'b0;
    be       = '0;
    br_type  = BR_NONE;
    legal    = 1'b1;
    case (opcode)
      OPCODE_OP: begin
        wen_raw = 1'b1;
        wbsel   = WB_ALU;
        if (funct7 == F7_BASE)                              alu_c = alu_from_f3(funct3);
        else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB)  alu_c = ALU_SUB;
        else if (funct7 == F7_ALT && funct3 == F3_SRL_SRA)  alu_c = ALU_SRA;
        else if (EN_M && funct7 == F7_MULDIV)               alu_c = 5'(ALU_MUL) + {2'b00, funct3};
        else                                                legal = 1'b0;
      end
      OPCODE_OP_IMM: begin
        wen_raw = 1'b1;
        wbsel   = WB_ALU;
        bsel    = 1'b1;
        alu_c   = alu_from_f3(funct3);
        if (funct3 == F3_SLL && funct7 != F7_BASE) legal = 1'b0;
        if (funct3 == F3_SRL_SRA) begin
          if (funct7 == F7_ALT)        alu_c = ALU_SRA;
          else if (funct7 != F7_BASE)  legal = 1'b0;
        end
      end
      OPCODE_LOAD: begin
        wen_raw  = 1'b1;
        bsel     = 1'b1;
        dmem_ren = 1'b1;
        usel     = funct3[2];
        be       = BE_W'(size_mask(funct3[1:0]));
        legal    = (funct3[1:0] != 2'b11) && (funct3 != 3'b110);
      end
      OPCODE_STORE: begin
        imm_sel  = IMM_S;
        bsel     = 1'b1;
        dmem_wen = 1'b1;
        be       = BE_W'(size_mask(funct3[1:0]));
        legal    = !funct3[2] && (funct3[1:0] != 2'b11);
      end
      OPCODE_BRANCH: begin
        imm_sel = IMM_B;
        asel    = 1'b1;
        bsel    = 1'b1;
        case (funct3)
          3'b000:  br_type = BR_EQ;
          3'b001:  br_type = BR_NE;
          3'b100:  br_type = BR_LT;
          3'b101:  br_type = BR_GE;
          3'b110:  br_type = BR_LTU;
          3'b111:  br_type = BR_GEU;
          default: legal   = 1'b0;
        endcase
      end
      OPCODE_JAL: begin
        imm_sel = IMM_J;
        wen_raw = 1'b1;
        asel    = 1'b1;
        bsel    = 1'b1;
        wbsel   = WB_PC4;
        br_type = BR_JUMP;
      end
      OPCODE_JALR: begin
        wen_raw = 1'b1;
        bsel    = 1'b1;
        wbsel   = WB_PC4;
        br_type = BR_JUMP;
        legal   = (funct3 == 3'b000);
      end
      OPCODE_LUI: begin
        imm_sel = IMM_U;
        wen_raw = 1'b1;
        bsel    = 1'b1;
        alu_c   = ALU_PASSB;
        wbsel   = WB_ALU;
      end
      OPCODE_AUIPC: begin
        imm_sel = IMM_U;
        wen_raw = 1'b1;
        asel    = 1'b1;
        bsel    = 1'b1;
        wbsel   = WB_ALU;
      end
      OPCODE_FENCE:  legal = (funct3 == 3'b000);
      OPCODE_SYSTEM: legal = 1'b0;
      default:       legal = 1'b0;
    endcase
    if (!legal) begin
      imm_sel  = IMM_I;
      wen_raw  = 1'b0;
      asel     = 1'b0;
      bsel     = 1'b0;
      alu_c    = ALU_ADD;
      dmem_wen = 1'b0;
      dmem_ren = 1'b0;
      wbsel    = WB_DMEM;
      usel     = 1'b0;
      be       = '0;
      br_type  = BR_NONE;
    end
    illegal = !legal;
    reg_wen = wen_raw && (rd != 5'd0);
    alu_sel = ALU_W'(alu_c);
  end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// Registered main-control decoder: combinational decode feeding a 2-entry
// skid buffer toward EX, with flush and a saturating accept counter.
//
// Handshake: a word moves on a port only in a cycle where valid && ready at
// the rising edge. in_ready is a pure register output (!entry1_full), so there
// is no combinational path from out_ready. Outputs hold while out_valid && !out_ready.
module ctrl_decode_pipe
  import ctrl_decode_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter bit EN_M  = 1'b0,
  parameter int ALU_W = 5,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         inst,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2:0]          imm_sel,
  output logic                reg_wen,
  output logic                asel,
  output logic                bsel,
  output logic [ALU_W-1:0]    alu_sel,
  output logic                dmem_wen,
  output logic                dmem_ren,
  output logic [1:0]          wbsel,
  output logic                usel,
  output logic [XLEN/8-1:0]   be,
  output logic [2:0]          br_type,
  output logic                illegal,
  output logic [CNT_W-1:0]    dec_cnt
);

  localparam int BE_W  = XLEN / 8;
  localparam int BUN_W = 3 + 1 + 1 + 1 + ALU_W + 1 + 1 + 2 + 1 + BE_W + 3 + 1;

  logic [2:0]       d_imm_sel;
  logic             d_reg_wen, d_asel, d_bsel, d_dmem_wen, d_dmem_ren, d_usel, d_illegal;
  logic [ALU_W-1:0] d_alu_sel;
  logic [1:0]       d_wbsel;
  logic [BE_W-1:0]  d_be;
  logic [2:0]       d_br_type;
  logic [BUN_W-1:0] dec_bundle;

  logic             e0_valid, e1_valid;
  logic [BUN_W-1:0] e0_data, e1_data;
  logic             push, pop;

  ctrl_decode_pipe_comb #(
    .EN_M (EN_M),
    .ALU_W(ALU_W),
    .BE_W (BE_W)
  ) u_decode (
    .inst    (inst),
    .imm_sel (d_imm_sel),
    .reg_wen (d_reg_wen),
    .asel    (d_asel),
    .bsel    (d_bsel),
    .alu_sel (d_alu_sel),
    .dmem_wen(d_dmem_wen),
    .dmem_ren(d_dmem_ren),
    .wbsel   (d_wbsel),
    .usel    (d_usel),
    .be      (d_be),
    .br_type (d_br_type),
    .illegal (d_illegal)
  );

  assign dec_bundle = {d_imm_sel, d_reg_wen, d_asel, d_bsel, d_alu_sel, d_dmem_wen,
                       d_dmem_ren, d_wbsel, d_usel, d_be, d_br_type, d_illegal};

  assign in_ready  = !e1_valid;
  assign out_valid = e0_valid;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = e0_valid && out_ready;

  assign {imm_sel, reg_wen, asel, bsel, alu_sel, dmem_wen, dmem_ren,
          wbsel, usel, be, br_type, illegal} = e0_data;

  // skid buffer: entry0 is the head, entry1 only fills when the head stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      e0_valid <= 1'b0;
      e1_valid <= 1'b0;
      e0_data  <= '0;
      e1_data  <= '0;
    end else if (flush) begin
      e0_valid <= 1'b0;
      e1_valid <= 1'b0;
    end else if (e1_valid) begin
      if (pop) begin
        e0_data  <= e1_data;
        e1_valid <= 1'b0;
      end
    end else if (e0_valid) begin
      if (pop && push) begin
        e0_data <= dec_bundle;
      end else if (pop) begin
        e0_valid <= 1'b0;
      end else if (push) begin
        e1_data  <= dec_bundle;
        e1_valid <= 1'b1;
      end
    end else if (push) begin
      e0_data  <= dec_bundle;
      e0_valid <= 1'b1;
    end
  end

  // count accepted instructions, sticking at all-ones
  always_ff @(posedge clk) begin
    if (rst)                        dec_cnt <= '0;
    else if (push && dec_cnt != '1) dec_cnt <= dec_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Bench for ctrl_decode_pipe: one default instance (EN_M=0, CNT_W=16) and one
// with EN_M=1, CNT_W=2, driven by the same stimulus. A FIFO of accepted words
// plus a rule-based decoder predicts every visible output.
module tb_ctrl_decode_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] inst;

  logic        in_ready0, out_valid0, reg_wen0, asel0, bsel0, dmem_wen0, dmem_ren0, usel0, illegal0;
  logic [2:0]  imm_sel0, br_type0;
  logic [4:0]  alu_sel0;
  logic [1:0]  wbsel0;
  logic [3:0]  be0;
  logic [15:0] dec_cnt0;

  logic        in_ready1, out_valid1, reg_wen1, asel1, bsel1, dmem_wen1, dmem_ren1, usel1, illegal1;
  logic [2:0]  imm_sel1, br_type1;
  logic [4:0]  alu_sel1;
  logic [1:0]  wbsel1;
  logic [3:0]  be1;
  logic [1:0]  dec_cnt1;

  logic [23:0] b0, b1;

  logic [31:0] exp_q[$];
  int          cnt0, cnt1;
  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;

  logic [4:0] alu_tab [8] = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9};
  logic [2:0] br_tab  [8] = '{3'd1, 3'd2, 3'd0, 3'd0, 3'd3, 3'd4, 3'd5, 3'd6};
  logic [6:0] ops     [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
                               7'h67, 7'h37, 7'h17, 7'h0F, 7'h73};

  ctrl_decode_pipe #(.XLEN(32), .EN_M(1'b0), .ALU_W(5), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .inst(inst), .out_valid(out_valid0), .out_ready(out_ready), .imm_sel(imm_sel0),
    .reg_wen(reg_wen0), .asel(asel0), .bsel(bsel0), .alu_sel(alu_sel0),
    .dmem_wen(dmem_wen0), .dmem_ren(dmem_ren0), .wbsel(wbsel0), .usel(usel0),
    .be(be0), .br_type(br_type0), .illegal(illegal0), .dec_cnt(dec_cnt0)
  );

  ctrl_decode_pipe #(.XLEN(32), .EN_M(1'b1), .ALU_W(5), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .inst(inst), .out_valid(out_valid1), .out_ready(out_ready), .imm_sel(imm_sel1),
    .reg_wen(reg_wen1), .asel(asel1), .bsel(bsel1), .alu_sel(alu_sel1),
    .dmem_wen(dmem_wen1), .dmem_ren(dmem_ren1), .wbsel(wbsel1), .usel(usel1),
    .be(be1), .br_type(br_type1), .illegal(illegal1), .dec_cnt(dec_cnt1)
  );

  assign b0 = {imm_sel0, reg_wen0, asel0, bsel0, alu_sel0, dmem_wen0, dmem_ren0,
               wbsel0, usel0, be0, br_type0, illegal0};
  assign b1 = {imm_sel1, reg_wen1, asel1, bsel1, alu_sel1, dmem_wen1, dmem_ren1,
               wbsel1, usel1, be1, br_type1, illegal1};

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected bundle {imm,rw,asel,bsel,alu,wen,ren,wb,usel,be,br,ill} and a care
  // mask; fields that carry no meaning for an instruction class are masked out.
  function automatic void ref_decode(input logic [31:0] w, input bit en_m,
                                     output logic [23:0] e, output logic [23:0] m);
    logic [6:0] op, f7;
    logic [2:0] f3, imm, br;
    logic       rw, a, b, sw, sr, u, ok, mem, uses_imm, writes;
    logic [4:0] alu;
    logic [1:0] wb;
    logic [3:0] be;
    int         nb;
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    imm = 3'd0; br = 3'd0; rw = 0; a = 0; b = 0; sw = 0; sr = 0; u = 0;
    alu = 5'd0; wb = 2'd0; be = 4'd0; ok = 1; mem = 0; uses_imm = 1; writes = 0;
    nb = 1 << f3[1:0];
    case (op)
      7'h33: begin
        uses_imm = 0; rw = 1; writes = 1; wb = 2'd1;
        if (f7 == 7'h00)                    alu = alu_tab[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) alu = 5'd1;
        else if (f7 == 7'h20 && f3 == 3'd5) alu = 5'd7;
        else if (f7 == 7'h01 && en_m)       alu = 5'd11 + 5'(f3);
        else                                ok = 0;
      end
      7'h13: begin
        rw = 1; writes = 1; wb = 2'd1; b = 1; alu = alu_tab[f3];
        if (f3 == 3'd1 && f7 != 7'h00) ok = 0;
        if (f3 == 3'd5) begin
          if (f7 == 7'h20)       alu = 5'd7;
          else if (f7 != 7'h00)  ok = 0;
        end
      end
      7'h03: begin
        rw = 1; writes = 1; b = 1; sr = 1; mem = 1; u = f3[2];
        be = 4'((1 << nb) - 1);
        ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      end
      7'h23: begin
        imm = 3'd1; b = 1; sw = 1; mem = 1;
        be = 4'((1 << nb) - 1);
        ok = (f3 <= 3'd2);
      end
      7'h63: begin imm = 3'd2; a = 1; b = 1; br = br_tab[f3]; ok = (br != 3'd0); end
      7'h6F: begin imm = 3'd4; a = 1; b = 1; wb = 2'd2; br = 3'd7; rw = 1; writes = 1; end
      7'h67: begin b = 1; wb = 2'd2; br = 3'd7; rw = 1; writes = 1; ok = (f3 == 3'd0); end
      7'h37: begin imm = 3'd3; b = 1; alu = 5'd10; wb = 2'd1; rw = 1; writes = 1; end
      7'h17: begin imm = 3'd3; a = 1; b = 1; wb = 2'd1; rw = 1; writes = 1; end
      7'h0F: begin uses_imm = 0; ok = (f3 == 3'd0); end
      default: ok = 0;
    endcase
    if (w[11:7] == 5'd0) rw = 0;
    e = {imm, rw, a, b, alu, sw, sr, wb, u, be, br, 1'b0};
    m = '1;
    if (!uses_imm) m[23:21] = 3'd0;
    if (!mem)      m[8:4]   = 5'd0;
    if (!writes)   m[10:9]  = 2'd0;
    if (!ok) begin
      e = 24'h000001;
      m = 24'h101801;
    end
  endfunction

  // scoreboard: compare every visible output against the model
  task automatic check_state();
    logic [23:0] e, m;
    chk("in_ready0", in_ready0, exp_q.size() < 2);
    chk("in_ready1", in_ready1, exp_q.size() < 2);
    chk("out_valid0", out_valid0, exp_q.size() > 0);
    chk("out_valid1", out_valid1, exp_q.size() > 0);
    chk("dec_cnt0", dec_cnt0, cnt0);
    chk("dec_cnt1", dec_cnt1, cnt1);
    if (exp_q.size() > 0) begin
      ref_decode(exp_q[0], 1'b0, e, m);
      chk("bundle0", b0 & m, e & m);
      ref_decode(exp_q[0], 1'b1, e, m);
      chk("bundle1", b1 & m, e & m);
    end
  endtask

  // driver: one clock with the given inputs, then advance the model
  task automatic cycle(input logic v, input logic [31:0] w, input logic ordy, input logic fl);
    bit acc, pop;
    in_valid = v; inst = w; out_ready = ordy; flush = fl;
    acc = v && (exp_q.size() < 2) && !fl;
    pop = (exp_q.size() > 0) && ordy;
    @(posedge clk); #1;
    if (fl) exp_q.delete();
    else begin
      if (pop) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(w);
        if (cnt0 < 65535) cnt0++;
        if (cnt1 < 3) cnt1++;
      end
    end
    check_state();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; inst = '0;
    repeat (n) @(posedge clk);
    #1;
    exp_q.delete(); cnt0 = 0; cnt1 = 0;
    chk("rst_bundle0", b0, 0);
    chk("rst_bundle1", b1, 0);
    check_state();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    int          sel;
    w = $urandom();
    sel = $urandom_range(0, 15);
    if (sel < 11) w[6:0] = ops[sel];
    case ($urandom_range(0, 3))
      0:       w[31:25] = 7'h00;
      1:       w[31:25] = 7'h20;
      2:       w[31:25] = 7'h01;
      default: ;
    endcase
    if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  initial begin
    bit          v, ordy, fl, hold, acc_pre;
    logic [31:0] w;

    // reset held two cycles, then idle: nothing appears before an accept
    do_reset(2);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // add a0,a0,a1 with one-cycle latency
    cycle(1'b1, 32'h00B50533, 1'b1, 1'b0);
    chk("add_valid", out_valid0, 1);
    chk("add_alu", alu_sel0, 0);
    chk("add_wen", reg_wen0, 1);
    chk("add_bsel", bsel0, 0);
    chk("add_wbsel", wbsel0, 1);
    chk("add_cnt", dec_cnt0, 1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // lw, lbu, sw against a stalled consumer, then release
    cycle(1'b1, 32'h0004A283, 1'b0, 1'b0);
    chk("ready_after_1", in_ready0, 1);
    cycle(1'b1, 32'h0004C283, 1'b0, 1'b0);
    chk("ready_after_2", in_ready0, 0);
    chk("lw_be", be0, 4'b1111);
    cycle(1'b1, 32'h0054A023, 1'b0, 1'b0);
    chk("lw_hold_be", be0, 4'b1111);
    cycle(1'b1, 32'h0054A023, 1'b1, 1'b0);
    chk("lbu_be", be0, 4'b0001);
    chk("lbu_usel", usel0, 1);
    cycle(1'b1, 32'h0054A023, 1'b1, 1'b0);
    chk("sw_wen", dmem_wen0, 1);
    chk("sw_regwen", reg_wen0, 0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // mul: illegal without M, MUL with M
    cycle(1'b1, 32'h02B50533, 1'b1, 1'b0);
    chk("mul_ill_m0", illegal0, 1);
    chk("mul_wen_m0", reg_wen0, 0);
    chk("mul_ill_m1", illegal1, 0);
    chk("mul_alu_m1", alu_sel1, 11);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // two buffered, then flush alongside a valid instruction
    cycle(1'b1, 32'h00100093, 1'b0, 1'b0);
    cycle(1'b1, 32'h00B50533, 1'b0, 1'b0);
    cycle(1'b1, 32'h00C58633, 1'b0, 1'b1);
    chk("flush_valid", out_valid0, 0);
    chk("flush_ready", in_ready0, 1);
    chk("flush_cnt0", dec_cnt0, 7);
    chk("sat_cnt1", dec_cnt1, 3);

    // mid-stream reset, then saturate the 2-bit counter again
    cycle(1'b1, 32'h00100093, 1'b0, 1'b0);
    do_reset(1);
    chk("mrst_cnt1", dec_cnt1, 0);
    chk("mrst_valid1", out_valid1, 0);
    chk("mrst_ready1", in_ready1, 1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h00100093, 1'b1, 1'b0);
    chk("five_cnt1", dec_cnt1, 3);
    chk("five_cnt0", dec_cnt0, 5);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // randomized traffic; a refused word is held until it is taken
    hold = 0; v = 0; w = '0;
    for (int i = 0; i < 600; i++) begin
      if (!hold) begin
        v = ($urandom_range(0, 3) != 0);
        w = rand_inst();
      end
      ordy = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 40) == 0);
      acc_pre = v && (exp_q.size() < 2) && !fl;
      cycle(v, w, ordy, fl);
      hold = v && !acc_pre && !fl;
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
